bist_sequencer: RTL and testbench

Multi-session BIST controller for the scan-chain core-under-test (CUT) datapath. It drives the LFSR seed/load, MISR clear, and scan_en. It runs N_SESSIONS sessions, each with N_PATTERNS shift/capture patterns. After each session it compares the MISR signature against a per-session golden value and aggregates pass/fail. It replaces the single-session control and compare path in the BIST top level; the CUT input mux is driven from scan_en as before.

---
 rtl/bist_sequencer_pkg.sv | 17 +
 rtl/bist_seq_counter.sv | 40 ++++
 rtl/bist_sequencer.sv | 165 ++++++++++++++++
 tb/tb_bist_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_sequencer_pkg.sv
// Shared types and widths for the multi-session BIST sequencer.
package bist_pkg;

    localparam int unsigned SEED_IDX_W  = 3;
    localparam int unsigned FAIL_MASK_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SHIFT,
        ST_CAPTURE,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

endpackage

// File: rtl/bist_seq_counter.sv
// Loadable down-counter with terminal-count flag (tc = count is zero).
// Load has priority over enable; the counter holds at zero instead of wrapping.
module bist_seq_counter #(
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign count = count_q;
    assign tc    = (count_q == '0);

    // Next count: load, decrement, or hold at terminal count.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && !tc) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bist_sequencer.sv
// Multi-session BIST controller: seeds the LFSR, clears the MISR, sequences
// shift/capture patterns and a final flush, then compares the MISR signature
// against a per-session golden value.
// Optional build macro BIST_SEQ_STOP_ON_FAIL_EN: stop at the first failing
// session instead of running all sessions.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = 8,
    parameter int unsigned N_PATTERNS = 16,
    parameter int unsigned N_SESSIONS = 2,
    parameter int unsigned SIG_W      = 6,
    parameter logic [N_SESSIONS*SIG_W-1:0] GOLDEN = {6'h2D, 6'h13}
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [SIG_W-1:0]       sig_in,
    output logic                   scan_en,
    output logic                   seed_load,
    output logic [SEED_IDX_W-1:0]  seed_idx,
    output logic                   misr_clr,
    output logic                   running,
    output logic                   bist_end,
    output logic                   pass_fail,
    output logic [FAIL_MASK_W-1:0] fail_mask
);

    localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PAT_W   = $clog2(N_PATTERNS + 1);

    bist_state_t            state_q, state_d;
    logic [SEED_IDX_W-1:0]  seed_idx_q, seed_idx_d;
    logic [FAIL_MASK_W-1:0] fail_mask_q, fail_mask_d;
    logic                   start_q, start_qq;
    logic                   scan_en_q, scan_en_d;
    logic                   seed_load_q, seed_load_d;
    logic                   misr_clr_q, misr_clr_d;
    logic                   running_q, running_d;
    logic                   bist_end_q, bist_end_d;
    logic                   pass_fail_q, pass_fail_d;

    logic               start_rise;
    logic               shift_load, shift_en, shift_tc;
    logic               pat_load, pat_en, pat_tc;
    logic [SHIFT_W-1:0] shift_cnt;
    logic [PAT_W-1:0]   pat_cnt;
    logic [SIG_W-1:0]   golden_slice;
    logic               last_session;
    logic               mismatch;

    assign start_rise   = start_q & ~start_qq;
    assign golden_slice = GOLDEN[int'(seed_idx_q)*SIG_W +: SIG_W];
    assign last_session = (seed_idx_q == SEED_IDX_W'(N_SESSIONS - 1));
    assign mismatch     = (sig_in != golden_slice);

    // Shift counter reloads outside SHIFT/FLUSH so each burst starts at CHAIN_LEN-1.
    assign shift_load = !(state_q == ST_SHIFT || state_q == ST_FLUSH);
    assign shift_en   = !shift_load;
    assign pat_load   = (state_q == ST_SEED);
    assign pat_en     = (state_q == ST_CAPTURE);

    bist_seq_counter #(.W(SHIFT_W)) u_shift_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (shift_load),
        .load_val (SHIFT_W'(CHAIN_LEN - 1)),
        .en       (shift_en),
        .count    (shift_cnt),
        .tc       (shift_tc)
    );

    bist_seq_counter #(.W(PAT_W)) u_pat_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (pat_load),
        .load_val (PAT_W'(N_PATTERNS - 1)),
        .en       (pat_en),
        .count    (pat_cnt),
        .tc       (pat_tc)
    );

    // Next-state, session bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        seed_idx_d  = seed_idx_q;
        fail_mask_d = fail_mask_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    state_d     = ST_SEED;
                    seed_idx_d  = '0;
                    fail_mask_d = '0;
                end
            end
            ST_SEED:    state_d = ST_SHIFT;
            ST_SHIFT:   if (shift_tc) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = pat_tc ? ST_FLUSH : ST_SHIFT;
            ST_FLUSH:   if (shift_tc) state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (mismatch) begin
                    fail_mask_d[seed_idx_q] = 1'b1;
                end
`ifdef BIST_SEQ_STOP_ON_FAIL_EN
                if (last_session || mismatch) begin
`else
                if (last_session) begin
`endif
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_SEED;
                    seed_idx_d = seed_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs decoded from the next state so they line up with it.
        scan_en_d   = (state_d == ST_SHIFT) || (state_d == ST_FLUSH);
        seed_load_d = (state_d == ST_SEED);
        misr_clr_d  = (state_d == ST_SEED);
        running_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        bist_end_d  = (state_d == ST_DONE);
        pass_fail_d = (state_d == ST_DONE) && (fail_mask_d == '0);
    end

    // FSM state, session registers, start edge detect and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            seed_idx_q  <= '0;
            fail_mask_q <= '0;
            start_q     <= 1'b0;
            start_qq    <= 1'b0;
            scan_en_q   <= 1'b0;
            seed_load_q <= 1'b0;
            misr_clr_q  <= 1'b0;
            running_q   <= 1'b0;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_idx_q  <= seed_idx_d;
            fail_mask_q <= fail_mask_d;
            start_q     <= start;
            start_qq    <= start_q;
            scan_en_q   <= scan_en_d;
            seed_load_q <= seed_load_d;
            misr_clr_q  <= misr_clr_d;
            running_q   <= running_d;
            bist_end_q  <= bist_end_d;
            pass_fail_q <= pass_fail_d;
        end
    end

    assign scan_en   = scan_en_q;
    assign seed_load = seed_load_q;
    assign seed_idx  = seed_idx_q;
    assign misr_clr  = misr_clr_q;
    assign running   = running_q;
    assign bist_end  = bist_end_q;
    assign pass_fail = pass_fail_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Self-checking bench for bist_sequencer with default parameters.
// Expected run results are pushed to a scoreboard when a run is started and
// popped when the DUT raises bist_end.
module tb_bist_sequencer;

    localparam int SESS_LEN = 154;
    localparam logic [5:0] GOLD0 = 6'h13;
    localparam logic [5:0] GOLD1 = 6'h2D;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [5:0] sig_in;
    logic       scan_en;
    logic       seed_load;
    logic [2:0] seed_idx;
    logic       misr_clr;
    logic       running;
    logic       bist_end;
    logic       pass_fail;
    logic [7:0] fail_mask;

    typedef struct {
        logic [7:0] mask;
        logic       pass;
        logic [2:0] idx;
        int         len;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] sig_tab [2];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    bist_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .sig_in    (sig_in),
        .scan_en   (scan_en),
        .seed_load (seed_load),
        .seed_idx  (seed_idx),
        .misr_clr  (misr_clr),
        .running   (running),
        .bist_end  (bist_end),
        .pass_fail (pass_fail),
        .fail_mask (fail_mask)
    );

    // MISR stand-in: the signature presented depends on the active session.
    assign sig_in = sig_tab[seed_idx[0]];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected scan_en at offset t from SEED entry.
    function automatic logic exp_scan(input int t);
        int p;
        p = t % SESS_LEN;
        if (p == 0) return 1'b0;
        if (p <= 144) return ((p - 1) % 9) != 8;
        if (p <= 152) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_expected();
        exp_t e;
        logic [5:0] gold [2];
        gold[0] = GOLD0;
        gold[1] = GOLD1;
        e.mask = '0;
        e.len  = 0;
        e.idx  = '0;
        for (int s = 0; s < 2; s++) begin
            e.idx = 3'(s);
            e.len += SESS_LEN;
            if (sig_tab[s] != gold[s]) begin
                e.mask[s] = 1'b1;
`ifdef BIST_SEQ_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        e.pass = (e.mask == '0);
        sb.push_back(e);
    endtask

    // Raise start (optionally keep it high) and return the cycle it was applied.
    task automatic kick(input bit hold, output int k);
        k = cyc;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_seed(input int k, output int t0);
        int n;
        n = 0;
        while (!seed_load && n < 10) begin
            step();
            n++;
        end
        check_val("seed_latency", 32'(cyc - k), 32'd2);
        check_val("seed_pulse", {29'd0, seed_load, misr_clr, scan_en}, 32'b110);
        t0 = cyc;
    endtask

    task automatic monitor_run(input int t0, input bit glitch);
        exp_t e;
        int   bad;
        int   t;
        bit   p0;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty got 0 expected 1");
            errors++;
            return;
        end
        e   = sb.pop_front();
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            t = cyc - t0;
            if (bist_end) break;
            if (t < e.len) begin
                p0 = (t % SESS_LEN) == 0;
                if (scan_en !== exp_scan(t)) bad++;
                if (seed_load !== p0 || misr_clr !== p0) bad++;
                if (running !== 1'b1) bad++;
                if (seed_idx !== 3'(t / SESS_LEN)) bad++;
            end else begin
                bad++;
            end
            if (glitch && t == 46) start = 1'b1;
            if (glitch && t == 47) start = 1'b0;
            step();
        end
        check_val("cycle_model", 32'(bad), 32'd0);
        check_val("run_len", 32'(cyc - t0), 32'(e.len));
        check_val("fail_mask", 32'(fail_mask), 32'(e.mask));
        check_val("pass_fail", 32'(pass_fail), 32'(e.pass));
        check_val("seed_idx_done", 32'(seed_idx), 32'(e.idx));
        check_val("done_flags", {29'd0, bist_end, running, scan_en}, 32'b100);
    endtask

    initial begin
        int k;
        int t0;
        int bad;
        RST   = 1'b1;
        start = 1'b0;
        sig_tab[0] = GOLD0;
        sig_tab[1] = GOLD1;
        repeat (3) step();
        check_val("reset_outs", {scan_en, seed_load, seed_idx, misr_clr, running,
                                 bist_end, pass_fail, fail_mask}, 32'd0);
        RST = 1'b0;
        step();

        // Run 1: all sessions match; a start edge mid-run must be ignored.
        kick(1'b0, k);
        push_expected();
        wait_seed(k, t0);
        monitor_run(t0, 1'b1);

        // Run 2: session 1 mismatches.
        sig_tab[1] = 6'h00;
        kick(1'b0, k);
        push_expected();
        wait_seed(k, t0);
        monitor_run(t0, 1'b0);

        // Run 3: session 0 mismatches.
        sig_tab[0] = 6'h00;
        sig_tab[1] = GOLD1;
        kick(1'b0, k);
        push_expected();
        wait_seed(k, t0);
        monitor_run(t0, 1'b0);

        // Asynchronous reset in the middle of a SHIFT burst.
        sig_tab[0] = GOLD0;
        kick(1'b0, k);
        wait_seed(k, t0);
        repeat (96) step();
        check_val("pre_rst_running", 32'(running), 32'd1);
        #3 RST = 1'b1;
        #1;
        check_val("rst_async", {scan_en, seed_load, seed_idx, misr_clr, running,
                                bist_end, pass_fail, fail_mask}, 32'd0);
        step();
        RST = 1'b0;
        step();

        // Run 4: full run after reset, start held high through DONE.
        sig_tab[1] = 6'h00;
        kick(1'b1, k);
        push_expected();
        wait_seed(k, t0);
        monitor_run(t0, 1'b0);
        bad = 0;
        repeat (30) begin
            step();
            if (seed_load || running || !bist_end) bad++;
        end
        check_val("hold_no_retrigger", 32'(bad), 32'd0);
        start = 1'b0;
        step();
        step();

        // Run 5: restart from DONE clears the previous failure.
        sig_tab[1] = GOLD1;
        kick(1'b0, k);
        push_expected();
        wait_seed(k, t0);
        monitor_run(t0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
